// File: rtl/lsu_axi_sram.sv
// AXI4-Lite responder memory for the LSU master port.
// Word-addressed array with independent read and write FSMs. Each channel returns
// its response a fixed or LFSR-derived number of cycles after the handshake.
module lsu_axi_sram #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          RD_LAT    = 2,
    parameter int          WR_LAT    = 1,
    parameter bit          RAND_EN   = 1'b0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_e;

    logic [31:0] mem [DEPTH];
    logic [31:0] mem_rdata;

    // In range iff at or above the base and the word offset fits the array;
    // the two low address bits never matter.
    function automatic logic addr_hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> (ADDR_W + 2)) == 32'd0);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return ADDR_W'(off >> 2);
    endfunction

    logic [7:0]  lfsr_q, lfsr_d;
    logic [7:0]  rd_lat, wr_lat;

    r_state_e    r_state_q, r_state_d;
    logic [7:0]  r_cnt_q, r_cnt_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arready_q, arready_d;
    logic        rd_hit_q, rd_hit_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rd_sample;
    logic [31:0] rd_addr;
    logic        ar_hs;

    w_state_e    w_state_q, w_state_d;
    logic [7:0]  w_cnt_q, w_cnt_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        wr_commit;
    logic        aw_hs, w_hs;

    assign ar_hs  = lsu_arvalid && arready_q;
    assign aw_hs  = lsu_awvalid && awready_q;
    assign w_hs   = lsu_wvalid && wready_q;
    assign rd_lat = RAND_EN ? {5'd0, lfsr_q[2:0]} : 8'(RD_LAT);
    assign wr_lat = RAND_EN ? {5'd0, lfsr_q[2:0]} : 8'(WR_LAT);

    assign lsu_arready = arready_q;
    assign lsu_rvalid  = (r_state_q == R_RESP);
    assign lsu_rdata   = rd_hit_q ? mem_rdata : 32'd0;
    assign lsu_rresp   = rresp_q;
    assign lsu_awready = awready_q;
    assign lsu_wready  = wready_q;
    assign lsu_bvalid  = (w_state_q == W_RESP);
    assign lsu_bresp   = bresp_q;

    // Galois LFSR x^8+x^6+x^5+x^4+1, free-running only when random latency is on.
    always_comb begin
        lfsr_d = lfsr_q;
        if (RAND_EN) begin
            lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        end
    end

    // Read FSM: accept one address, count down the latency, then hold the response.
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        araddr_d  = araddr_q;
        rd_hit_d  = rd_hit_q;
        rresp_d   = rresp_q;
        rd_sample = 1'b0;
        rd_addr   = araddr_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    araddr_d = lsu_araddr;
                    rd_addr  = lsu_araddr;
                    r_cnt_d  = rd_lat;
                    if (rd_lat == 8'd0) begin
                        rd_sample = 1'b1;
                        r_state_d = R_RESP;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                r_cnt_d = r_cnt_q - 8'd1;
                if (r_cnt_q == 8'd1) begin
                    rd_sample = 1'b1;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (lsu_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_sample) begin
            rd_hit_d = addr_hit(rd_addr);
            rresp_d  = addr_hit(rd_addr) ? RESP_OKAY : RESP_SLVERR;
        end
        arready_d = (r_state_d == R_IDLE);
    end

    // Write FSM: collect AW and W in any order, count down, commit on response entry.
    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        bresp_d   = bresp_q;
        wr_commit = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awaddr_d = lsu_awaddr;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = lsu_wdata;
                    wstrb_d = lsu_wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    w_cnt_d  = wr_lat;
                    if (wr_lat == 8'd0) begin
                        wr_commit = 1'b1;
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                w_cnt_d = w_cnt_q - 8'd1;
                if (w_cnt_q == 8'd1) begin
                    wr_commit = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (lsu_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        if (wr_commit) begin
            bresp_d = addr_hit(awaddr_d) ? RESP_OKAY : RESP_SLVERR;
        end
        awready_d = (w_state_d == W_IDLE) && !aw_got_d;
        wready_d  = (w_state_d == W_IDLE) && !w_got_d;
    end

    // Array: synchronous read, byte-lane write; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (!rst && wr_commit && addr_hit(awaddr_d)) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_d[i]) mem[addr_idx(awaddr_d)][8*i +: 8] <= wdata_d[8*i +: 8];
            end
        end
        if (!rst && rd_sample) mem_rdata <= mem[addr_idx(rd_addr)];
    end

    // Control state registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q    <= LFSR_SEED;
            r_state_q <= R_IDLE;
            r_cnt_q   <= 8'd0;
            araddr_q  <= 32'd0;
            arready_q <= 1'b0;
            rd_hit_q  <= 1'b0;
            rresp_q   <= 2'b00;
            w_state_q <= W_IDLE;
            w_cnt_q   <= 8'd0;
            awaddr_q  <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            lfsr_q    <= lfsr_d;
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rd_hit_q  <= rd_hit_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bresp_q   <= bresp_d;
        end
    end
endmodule

// File: tb/tb_lsu_axi_sram.sv
// Self-checking bench for lsu_axi_sram with default latencies (read 2, write 1).
// Expected data comes from a word map kept here; latency is counted in clock edges.
module tb_lsu_axi_sram;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int RL = 2;
    localparam int WL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lsu_araddr = '0;
    logic        lsu_arvalid = 1'b0;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready = 1'b1;
    logic [31:0] lsu_awaddr = '0;
    logic        lsu_awvalid = 1'b0;
    logic        lsu_awready;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic        lsu_wvalid = 1'b0;
    logic        lsu_wready;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid;
    logic        lsu_bready = 1'b1;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] model [int];

    lsu_axi_sram dut (
        .clk(clk), .rst(rst),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
        .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'd4096);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!in_rng(a)) return 32'd0;
        return model[widx(a)];
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return in_rng(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!in_rng(a)) return;
        w = model.exists(widx(a)) ? model[widx(a)] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model[widx(a)] = w;
    endtask

    // ---------------- bus drivers ----------------
    // w_lead > 0: W offered that many cycles before AW; < 0: AW first.
    // proto_ok clears if a ready stays up after its beat, bvalid comes early,
    // or bvalid survives its handshake.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, output logic [1:0] resp, output int lat,
                            output bit proto_ok);
        bit aw_done, w_done, aw_hs, w_hs;
        int t, aw_start, w_start;
        aw_done = 0; w_done = 0; t = 0; proto_ok = 1; lat = -1; resp = 2'bxx;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            if ((w_done && lsu_wready) || (aw_done && lsu_awready) || lsu_bvalid) proto_ok = 0;
            lsu_awaddr  = a;
            lsu_wdata   = d;
            lsu_wstrb   = s;
            lsu_awvalid = !aw_done && (t >= aw_start);
            lsu_wvalid  = !w_done && (t >= w_start);
            aw_hs = lsu_awvalid && lsu_awready;
            w_hs  = lsu_wvalid && lsu_wready;
            @(posedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            t++;
            if (t > 60) begin
                n_chk++; n_err++;
                $display("FAIL write_handshake_timeout addr=%h waited=%0d cycles", a, t);
                lsu_awvalid = 0; lsu_wvalid = 0;
                return;
            end
        end
        @(negedge clk);
        lsu_awvalid = 0;
        lsu_wvalid  = 0;
        lat = 0;
        while (!lsu_bvalid) begin
            if (lat > 40) begin
                n_chk++; n_err++;
                $display("FAIL bvalid_timeout addr=%h waited=%0d cycles", a, lat);
                return;
            end
            if (lsu_awready || lsu_wready) proto_ok = 0;
            @(negedge clk);
            lat++;
        end
        resp = lsu_bresp;
        @(negedge clk);
        if (lsu_bvalid) proto_ok = 0;
    endtask

    // hold: cycles rready is kept low once rvalid is up. stable clears if rdata,
    // rresp or rvalid move during the stall, arready rises, or rvalid outlives its beat.
    task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                           output logic [1:0] r, output int lat, output bit stable);
        int k;
        stable = 1; lat = -1; d = 'x; r = 'x;
        @(negedge clk);
        lsu_araddr  = a;
        lsu_arvalid = 1;
        lsu_rready  = (hold == 0);
        k = 0;
        while (!lsu_arready) begin
            @(negedge clk);
            k++;
            if (k > 40) begin
                n_chk++; n_err++;
                $display("FAIL arready_timeout addr=%h waited=%0d cycles", a, k);
                lsu_arvalid = 0; lsu_rready = 1;
                return;
            end
        end
        @(negedge clk);
        lsu_arvalid = 0;
        lat = 0;
        while (!lsu_rvalid) begin
            if (lat > 40) begin
                n_chk++; n_err++;
                $display("FAIL rvalid_timeout addr=%h waited=%0d cycles", a, lat);
                lsu_rready = 1;
                return;
            end
            @(negedge clk);
            lat++;
        end
        d = lsu_rdata;
        r = lsu_rresp;
        if (lsu_arready) stable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!lsu_rvalid || lsu_rdata !== d || lsu_rresp !== r || lsu_arready) stable = 0;
        end
        lsu_rready = 1;
        @(negedge clk);
        if (lsu_rvalid) stable = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({lsu_arready, lsu_awready, lsu_wready, lsu_rvalid, lsu_bvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_handshake got=%b want=00000",
                     {lsu_arready, lsu_awready, lsu_wready, lsu_rvalid, lsu_bvalid});
        end
        n_chk++;
        if ({lsu_rdata, lsu_rresp, lsu_bresp} !== 36'd0) begin
            n_err++;
            $display("FAIL reset_data rdata=%h rresp=%b bresp=%b want all zero",
                     lsu_rdata, lsu_rresp, lsu_bresp);
        end
        rst = 0;
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [31:0] d; int lat; bit ok;
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, resp, lat, ok);
        model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        n_chk++;
        if (resp !== 2'b00 || lat != WL || !ok) begin
            n_err++;
            $display("FAIL basic_write bresp=%b lat=%0d proto=%0d want 00/%0d/1", resp, lat, ok, WL);
        end
        do_read(32'h8000_0010, 0, d, resp, lat, ok);
        n_chk++;
        if (d !== 32'hDEAD_BEEF || resp !== 2'b00) begin
            n_err++;
            $display("FAIL basic_read rdata=%h rresp=%b want deadbeef/00", d, resp);
        end
        n_chk++;
        if (lat != RL || !ok) begin
            n_err++;
            $display("FAIL basic_read_latency lat=%0d proto=%0d want %0d/1", lat, ok, RL);
        end
        // low address bits are ignored
        do_read(32'h8000_0013, 0, d, resp, lat, ok);
        n_chk++;
        if (d !== model_read(32'h8000_0010) || resp !== 2'b00) begin
            n_err++;
            $display("FAIL unaligned_read rdata=%h rresp=%b want %h/00", d, resp, model_read(32'h8000_0010));
        end
    endtask

    task automatic test_partial();
        logic [1:0] resp; logic [31:0] d; int lat; bit ok;
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, resp, lat, ok);
        model_write(32'h8000_0020, 32'h1122_3344, 4'hF);
        do_write(32'h8000_0020, 32'h0000_AB00, 4'b0010, 0, resp, lat, ok);
        model_write(32'h8000_0020, 32'h0000_AB00, 4'b0010);
        do_read(32'h8000_0020, 0, d, resp, lat, ok);
        n_chk++;
        if (d !== 32'h1122_AB44 || d !== model_read(32'h8000_0020)) begin
            n_err++;
            $display("FAIL partial_write rdata=%h want 1122ab44", d);
        end
        do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 0, resp, lat, ok);
        do_read(32'h8000_0020, 0, d, resp, lat, ok);
        n_chk++;
        if (d !== 32'h1122_AB44 || resp !== 2'b00) begin
            n_err++;
            $display("FAIL zero_strobe rdata=%h rresp=%b want 1122ab44/00", d, resp);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [31:0] d; int lat; bit ok;
        do_write(32'h8000_0040, 32'hCAFE_0001, 4'hF, 4, resp, lat, ok);
        model_write(32'h8000_0040, 32'hCAFE_0001, 4'hF);
        n_chk++;
        if (!ok || lat != WL || resp !== 2'b00) begin
            n_err++;
            $display("FAIL w_before_aw proto=%0d lat=%0d bresp=%b want 1/%0d/00", ok, lat, resp, WL);
        end
        do_write(32'h8000_0044, 32'hCAFE_0002, 4'hF, -3, resp, lat, ok);
        model_write(32'h8000_0044, 32'hCAFE_0002, 4'hF);
        n_chk++;
        if (!ok || lat != WL || resp !== 2'b00) begin
            n_err++;
            $display("FAIL aw_before_w proto=%0d lat=%0d bresp=%b want 1/%0d/00", ok, lat, resp, WL);
        end
        do_read(32'h8000_0040, 0, d, resp, lat, ok);
        n_chk++;
        if (d !== model_read(32'h8000_0040)) begin
            n_err++;
            $display("FAIL w_before_aw_data rdata=%h want %h", d, model_read(32'h8000_0040));
        end
    endtask

    task automatic test_rready_stall();
        logic [1:0] resp; logic [31:0] d; int lat; bit ok;
        do_read(32'h8000_0010, 5, d, resp, lat, ok);
        n_chk++;
        if (!ok || d !== model_read(32'h8000_0010) || lat != RL) begin
            n_err++;
            $display("FAIL rready_stall stable=%0d rdata=%h lat=%0d want 1/%h/%0d",
                     ok, d, lat, model_read(32'h8000_0010), RL);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] d; int lat; bit ok;
        do_write(BASE, 32'h0BAD_F00D, 4'hF, 0, resp, lat, ok);
        model_write(BASE, 32'h0BAD_F00D, 4'hF);
        do_write(BASE + 32'hFFC, 32'h5555_AAAA, 4'hF, 0, resp, lat, ok);
        model_write(BASE + 32'hFFC, 32'h5555_AAAA, 4'hF);
        n_chk++;
        if (resp !== 2'b00) begin
            n_err++;
            $display("FAIL last_word_write bresp=%b want 00", resp);
        end
        do_read(32'h7FFF_FFFC, 0, d, resp, lat, ok);
        n_chk++;
        if (d !== 32'd0 || resp !== 2'b10 || lat != RL) begin
            n_err++;
            $display("FAIL oor_read rdata=%h rresp=%b lat=%0d want 0/10/%0d", d, resp, lat, RL);
        end
        do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, resp, lat, ok);
        n_chk++;
        if (resp !== 2'b10 || lat != WL) begin
            n_err++;
            $display("FAIL oor_write bresp=%b lat=%0d want 10/%0d", resp, lat, WL);
        end
        do_read(BASE, 0, d, resp, lat, ok);
        n_chk++;
        if (d !== model_read(BASE)) begin
            n_err++;
            $display("FAIL oor_no_alias rdata=%h want %h", d, model_read(BASE));
        end
        do_read(BASE + 32'hFFC, 0, d, resp, lat, ok);
        n_chk++;
        if (d !== model_read(BASE + 32'hFFC) || resp !== 2'b00) begin
            n_err++;
            $display("FAIL last_word_read rdata=%h rresp=%b want %h/00", d, resp, model_read(BASE + 32'hFFC));
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [31:0] d; int lat, k; bit ok, seen;
        @(negedge clk);
        lsu_araddr = 32'h8000_0044;
        lsu_arvalid = 1;
        k = 0;
        while (!lsu_arready && k < 40) begin @(negedge clk); k++; end
        @(negedge clk);
        lsu_arvalid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (lsu_rvalid) seen = 1;
        end
        n_chk++;
        if (seen || k >= 40) begin
            n_err++;
            $display("FAIL reset_mid_read rvalid_seen=%0d arready_wait=%0d want 0", seen, k);
        end
        do_read(32'h8000_0044, 0, d, resp, lat, ok);
        n_chk++;
        if (d !== model_read(32'h8000_0044) || resp !== 2'b00 || lat != RL || !ok) begin
            n_err++;
            $display("FAIL after_reset_read rdata=%h rresp=%b lat=%0d want %h/00/%0d",
                     d, resp, lat, model_read(32'h8000_0044), RL);
        end
    endtask

    // read sampled on the very edge the write commits: old word comes back
    task automatic test_read_write_collide();
        logic [1:0] resp; logic [31:0] d, old; int lat, k; bit ok, rdy, got_r, got_b;
        old = model_read(32'h8000_0010);
        @(negedge clk);
        rdy = lsu_arready;
        lsu_araddr = 32'h8000_0010;
        lsu_arvalid = 1;
        @(negedge clk);
        lsu_arvalid = 0;
        rdy = rdy && lsu_awready && lsu_wready;
        lsu_awaddr = 32'h8000_0010; lsu_wdata = 32'h600D_CAFE; lsu_wstrb = 4'hF;
        lsu_awvalid = 1; lsu_wvalid = 1;
        @(negedge clk);
        lsu_awvalid = 0; lsu_wvalid = 0;
        model_write(32'h8000_0010, 32'h600D_CAFE, 4'hF);
        got_r = 0; got_b = 0; d = 'x; k = 0;
        while (!(got_r && got_b) && k < 40) begin
            if (lsu_rvalid && !got_r) begin got_r = 1; d = lsu_rdata; end
            if (lsu_bvalid) got_b = 1;
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (!rdy || !got_r || !got_b || d !== old) begin
            n_err++;
            $display("FAIL collide_old_data ready=%0d r=%0d b=%0d rdata=%h want %h", rdy, got_r, got_b, d, old);
        end
        do_read(32'h8000_0010, 0, d, resp, lat, ok);
        n_chk++;
        if (d !== model_read(32'h8000_0010)) begin
            n_err++;
            $display("FAIL collide_new_data rdata=%h want %h", d, model_read(32'h8000_0010));
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] oor [4];
        logic [31:0] a, d, wd; logic [1:0] resp; logic [3:0] s; int lat; bit ok;
        oor[0] = BASE - 4; oor[1] = BASE + 32'h1000; oor[2] = 32'h0; oor[3] = 32'hFFFF_FFFC;
        for (int i = 0; i < 8; i++) begin
            pool[i] = BASE + 32'h100 + 32'($urandom_range(0, 900)) * 4;
            wd = $urandom;
            do_write(pool[i], wd, 4'hF, 0, resp, lat, ok);
            model_write(pool[i], wd, 4'hF);
        end
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) == 0) ? oor[$urandom_range(0, 3)] : pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, wd, s, $urandom_range(0, 6) - 3, resp, lat, ok);
                model_write(a, wd, s);
                n_chk++;
                if (resp !== exp_resp(a) || lat != WL || !ok) begin
                    n_err++;
                    $display("FAIL rand_write addr=%h bresp=%b lat=%0d proto=%0d want %b/%0d/1",
                             a, resp, lat, ok, exp_resp(a), WL);
                end
            end else begin
                do_read(a, $urandom_range(0, 3), d, resp, lat, ok);
                n_chk++;
                if (d !== model_read(a) || resp !== exp_resp(a) || lat != RL || !ok) begin
                    n_err++;
                    $display("FAIL rand_read addr=%h rdata=%h rresp=%b lat=%0d stable=%0d want %h/%b/%0d/1",
                             a, d, resp, lat, ok, model_read(a), exp_resp(a), RL);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_w_before_aw();
        test_rready_stall();
        test_out_of_range();
        test_reset_mid();
        test_read_write_collide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
